// File: rtl/series_controller_pkg.sv
// Shared definitions for the series-evaluation control unit.
// Provides the state encoding (also used by the bench for state checks),
// the packed strobe bundle driven to the datapath, and its per-state decode.
package series_controller_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MULX  = 3'd2,
    MULC  = 3'd3,
    CHECK = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Control strobes towards the datapath plus handshake flags
  typedef struct packed {
    logic ready;
    logic done;
    logic count_en;
    logic iz_count;
    logic ldx;
    logic ldy;
    logic iz_a;
    logic lda;
    logic select_lut;
    logic select_x2;
    logic iz_tff;
    logic enable_tff;
    logic iz_r;
    logic ldr;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{ready: 1'b1, default: 1'b0};

  // Moore decode: the strobe set owned by each state
  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE: c.ready = 1'b1;
      INIT: begin
        c.iz_count = 1'b1;
        c.iz_a     = 1'b1;
        c.iz_tff   = 1'b1;
        c.iz_r     = 1'b1;
        c.ldx      = 1'b1;
        c.ldy      = 1'b1;
      end
      MULX: begin
        c.select_x2 = 1'b1;
        c.lda       = 1'b1;
      end
      MULC: begin
        c.select_lut = 1'b1;
        c.lda        = 1'b1;
      end
      CHECK: c = '0;
      ACC: begin
        c.ldr        = 1'b1;
        c.enable_tff = 1'b1;
        c.count_en   = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/series_controller.sv
// Control unit for the series-evaluation datapath.
// Sequences load/init/select/count strobes term by term after a start request,
// finishing when the datapath reports stop (in CHECK) or co (in ACC).
// Ports:
//   clk, rst (async active-low)
//   start  : level request, sampled in IDLE only
//   stop   : current term exceeds y (sampled in CHECK)
//   co     : LUT counter wrap (sampled in ACC)
//   count_en, iz_count, LdX, LdY, iz_A, LdA, select_lut, select_x2,
//   iz_TFF, enable_TFF, iz_R, LdR : datapath strobes
//   ready  : high in IDLE;  done : high for DONE_HOLD cycles at completion
module series_controller
  import series_controller_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic co,
  output logic count_en,
  output logic iz_count,
  output logic LdX,
  output logic LdY,
  output logic iz_A,
  output logic LdA,
  output logic select_lut,
  output logic select_x2,
  output logic iz_TFF,
  output logic enable_TFF,
  output logic iz_R,
  output logic LdR,
  output logic ready,
  output logic done
);

  localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_next;
  ctrl_t               r_ctrl;
  ctrl_t               w_ctrl_next;

  // State, DONE down-counter and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_ctrl  <= CTRL_RESET;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_ctrl  <= w_ctrl_next;
    end
  end

  // Next state; strobes are the decode of the next state so the registered
  // outputs always equal the decode of the registered state
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    case (r_state)
      IDLE:  if (start) w_state_next = INIT;
      INIT:  w_state_next = MULX;
      MULX:  w_state_next = MULC;
      MULC:  w_state_next = CHECK;
      CHECK: begin
        if (stop) begin
          w_state_next = DONE;
          w_hold_next  = HOLD_W'(DONE_HOLD - 1);
        end else begin
          w_state_next = ACC;
        end
      end
      ACC: begin
        if (co) begin
          w_state_next = DONE;
          w_hold_next  = HOLD_W'(DONE_HOLD - 1);
        end else begin
          w_state_next = MULX;
        end
      end
      DONE: begin
        if (r_hold == '0) w_state_next = IDLE;
        else              w_hold_next  = r_hold - HOLD_W'(1);
      end
      default: w_state_next = IDLE;
    endcase
    w_ctrl_next = decode_state(w_state_next);
  end

  assign count_en   = r_ctrl.count_en;
  assign iz_count   = r_ctrl.iz_count;
  assign LdX        = r_ctrl.ldx;
  assign LdY        = r_ctrl.ldy;
  assign iz_A       = r_ctrl.iz_a;
  assign LdA        = r_ctrl.lda;
  assign select_lut = r_ctrl.select_lut;
  assign select_x2  = r_ctrl.select_x2;
  assign iz_TFF     = r_ctrl.iz_tff;
  assign enable_TFF = r_ctrl.enable_tff;
  assign iz_R       = r_ctrl.iz_r;
  assign LdR        = r_ctrl.ldr;
  assign ready      = r_ctrl.ready;
  assign done       = r_ctrl.done;

endmodule

// File: tb/tb_series_controller.sv
// Bench for series_controller: one instance with DONE_HOLD=1 and one with
// DONE_HOLD=3 share the stimulus. Expected strobes per cycle come from a
// closed-form timeline model of a run (setup, 4-cycle terms, finish, idle).
module tb_series_controller;
  import series_controller_pkg::*;

  logic clk = 1'b0;
  logic rst, start, stop, co;

  logic a_count_en, a_iz_count, a_ldx, a_ldy, a_iz_a, a_lda, a_sel_lut, a_sel_x2;
  logic a_iz_tff, a_en_tff, a_iz_r, a_ldr, a_ready, a_done;
  logic b_count_en, b_iz_count, b_ldx, b_ldy, b_iz_a, b_lda, b_sel_lut, b_sel_x2;
  logic b_iz_tff, b_en_tff, b_iz_r, b_ldr, b_ready, b_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  series_controller #(.DONE_HOLD(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .co(co),
    .count_en(a_count_en), .iz_count(a_iz_count), .LdX(a_ldx), .LdY(a_ldy),
    .iz_A(a_iz_a), .LdA(a_lda), .select_lut(a_sel_lut), .select_x2(a_sel_x2),
    .iz_TFF(a_iz_tff), .enable_TFF(a_en_tff), .iz_R(a_iz_r), .LdR(a_ldr),
    .ready(a_ready), .done(a_done)
  );

  series_controller #(.DONE_HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .co(co),
    .count_en(b_count_en), .iz_count(b_iz_count), .LdX(b_ldx), .LdY(b_ldy),
    .iz_A(b_iz_a), .LdA(b_lda), .select_lut(b_sel_lut), .select_x2(b_sel_x2),
    .iz_TFF(b_iz_tff), .enable_TFF(b_en_tff), .iz_R(b_iz_r), .LdR(b_ldr),
    .ready(b_ready), .done(b_done)
  );

  logic [13:0] obs1, obs3;
  assign obs1 = {a_ready, a_done, a_count_en, a_iz_count, a_ldx, a_ldy, a_iz_a,
                 a_lda, a_sel_lut, a_sel_x2, a_iz_tff, a_en_tff, a_iz_r, a_ldr};
  assign obs3 = {b_ready, b_done, b_count_en, b_iz_count, b_ldx, b_ldy, b_iz_a,
                 b_lda, b_sel_lut, b_sel_x2, b_iz_tff, b_en_tff, b_iz_r, b_ldr};

  // Bit positions within obs vectors
  localparam logic [13:0] M_READY = 14'd1 << 13;
  localparam logic [13:0] M_DONE  = 14'd1 << 12;
  localparam logic [13:0] M_CEN   = 14'd1 << 11;
  localparam logic [13:0] M_IZC   = 14'd1 << 10;
  localparam logic [13:0] M_LDX   = 14'd1 << 9;
  localparam logic [13:0] M_LDY   = 14'd1 << 8;
  localparam logic [13:0] M_IZA   = 14'd1 << 7;
  localparam logic [13:0] M_LDA   = 14'd1 << 6;
  localparam logic [13:0] M_SELL  = 14'd1 << 5;
  localparam logic [13:0] M_SELX  = 14'd1 << 4;
  localparam logic [13:0] M_IZT   = 14'd1 << 3;
  localparam logic [13:0] M_ENT   = 14'd1 << 2;
  localparam logic [13:0] M_IZR   = 14'd1 << 1;
  localparam logic [13:0] M_LDR   = 14'd1;

  // Activity of each phase of a run
  localparam logic [13:0] A_IDLE   = M_READY;
  localparam logic [13:0] A_SETUP  = M_IZC | M_IZA | M_IZT | M_IZR | M_LDX | M_LDY;
  localparam logic [13:0] A_SQUARE = M_SELX | M_LDA;
  localparam logic [13:0] A_COEF   = M_SELL | M_LDA;
  localparam logic [13:0] A_TEST   = 14'd0;
  localparam logic [13:0] A_ACCUM  = M_LDR | M_ENT | M_CEN;
  localparam logic [13:0] A_FIN    = M_DONE;

  // Cycle (counted from the edge that samples start) on which done first shows:
  // stop in term s's test, or co in term c's accumulate, whichever comes first
  function automatic int finish_cycle(input int s, input int c);
    return (s <= c) ? 4 * s + 1 : 4 * c + 2;
  endfunction

  // Expected activity at cycle k of a run
  function automatic logic [13:0] exp_at(input int k, input int s, input int c,
                                         input int hold);
    int fin;
    fin = finish_cycle(s, c);
    if (k <= 0) return A_IDLE;
    if (k == 1) return A_SETUP;
    if (k >= fin + hold) return A_IDLE;
    if (k >= fin) return A_FIN;
    case ((k - 2) % 4)
      0:       return A_SQUARE;
      1:       return A_COEF;
      2:       return A_TEST;
      default: return A_ACCUM;
    endcase
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One run. mode: 0 start low, 1 start random, 2 start held high (ends on the
  // IDLE cycle with start still high), 3 start high in square/test cycles.
  // first_k=1 resumes a run already launched by a held start.
  task automatic run_plan(input int s, input int c, input int mode, input int first_k,
                          input bit chk3, output int done_at, output int n_ldr,
                          output int n_lda, output int n_cen, output int n_done1,
                          output int n_done3);
    int fin, last, t, ph;
    fin = finish_cycle(s, c);
    last = (mode == 2) ? fin + 1 : fin + 3;
    done_at = -1; n_ldr = 0; n_lda = 0; n_cen = 0; n_done1 = 0; n_done3 = 0;
    for (int k = first_k; k <= last; k++) begin
      @(negedge clk);
      chk($sformatf("trace_h1 s=%0d c=%0d m=%0d k=%0d", s, c, mode, k), obs1, exp_at(k, s, c, 1));
      if (chk3)
        chk($sformatf("trace_h3 s=%0d c=%0d m=%0d k=%0d", s, c, mode, k), obs3, exp_at(k, s, c, 3));
      chk($sformatf("sel_excl k=%0d", k), 14'(a_sel_lut & a_sel_x2), 14'd0);
      if (a_done && done_at < 0) done_at = k;
      n_ldr += int'(a_ldr);
      n_lda += int'(a_lda);
      n_cen += int'(a_count_en);
      n_done1 += int'(a_done);
      n_done3 += int'(b_done);
      // Next-edge inputs: flags are noise except on the cycle they are sampled
      stop = 1'($urandom);
      co   = 1'($urandom);
      t  = (k - 2) / 4 + 1;
      ph = (k - 2) % 4;
      if (k >= 2 && k < fin) begin
        if (ph == 2) stop = (t == s);
        if (ph == 3) co   = (t == c);
      end
      if (k == 0)         start = 1'b1;
      else if (k >= fin)  start = (mode == 2);
      else begin
        case (mode)
          1:       start = 1'($urandom);
          2:       start = 1'b1;
          3:       start = (k >= 2) && (ph == 0 || ph == 2);
          default: start = 1'b0;
        endcase
      end
    end
  endtask

  typedef struct {
    int s;
    int c;
    int mode;
    int done_at;
    int n_ldr;
    int n_lda;
    int n_cen;
  } vec_t;

  task automatic reset_both();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int d, nl, na, nc, n1, n3;

    tbl[0] = '{s: 9, c: 1, mode: 0, done_at: 6,  n_ldr: 1, n_lda: 2,  n_cen: 1};
    tbl[1] = '{s: 3, c: 8, mode: 0, done_at: 13, n_ldr: 2, n_lda: 6,  n_cen: 2};
    tbl[2] = '{s: 9, c: 8, mode: 3, done_at: 34, n_ldr: 8, n_lda: 16, n_cen: 8};
    tbl[3] = '{s: 1, c: 8, mode: 1, done_at: 5,  n_ldr: 0, n_lda: 2,  n_cen: 0};
    tbl[4] = '{s: 8, c: 8, mode: 1, done_at: 33, n_ldr: 7, n_lda: 16, n_cen: 7};
    tbl[5] = '{s: 5, c: 2, mode: 1, done_at: 10, n_ldr: 2, n_lda: 4,  n_cen: 2};

    rst = 1'b0; start = 1'b0; stop = 1'b0; co = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_h1", obs1, A_IDLE);
    chk("reset_h3", obs3, A_IDLE);
    rst = 1'b1;

    // Table-driven runs
    for (int i = 0; i < 6; i++) begin
      run_plan(tbl[i].s, tbl[i].c, tbl[i].mode, 0, 1'b1, d, nl, na, nc, n1, n3);
      chk_int($sformatf("done_at[%0d]", i), d, tbl[i].done_at);
      chk_int($sformatf("n_ldr[%0d]", i), nl, tbl[i].n_ldr);
      chk_int($sformatf("n_lda[%0d]", i), na, tbl[i].n_lda);
      chk_int($sformatf("n_cen[%0d]", i), nc, tbl[i].n_cen);
      chk_int($sformatf("n_done_h1[%0d]", i), n1, 1);
      chk_int($sformatf("n_done_h3[%0d]", i), n3, 3);
    end

    // start held through DONE: next run launches straight from the IDLE cycle
    run_plan(9, 1, 2, 0, 1'b0, d, nl, na, nc, n1, n3);
    chk_int("held_done_at", d, 6);
    run_plan(3, 8, 0, 1, 1'b0, d, nl, na, nc, n1, n3);
    chk_int("relaunch_done_at", d + 0, 13);
    chk_int("relaunch_n_ldr", nl, 2);
    reset_both();

    // Asynchronous reset during ACC
    @(negedge clk);
    start = 1'b1; stop = 1'b0; co = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_acc", obs1, A_ACCUM);
    #2 rst = 1'b0;
    #1;
    chk("midrun_reset_h1", obs1, A_IDLE);
    chk("midrun_reset_h3", obs3, A_IDLE);
    chk("midrun_reset_state", 14'(dut.r_state), 14'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Randomised runs against the timeline model
    for (int i = 0; i < 20; i++) begin
      int s, c, m;
      s = int'($urandom_range(1, 9));
      c = int'($urandom_range(1, 8));
      m = int'($urandom_range(0, 2));
      if (m == 2) m = 3;
      run_plan(s, c, m, 0, 1'b1, d, nl, na, nc, n1, n3);
      chk_int($sformatf("rand_done_at[%0d]", i), d, finish_cycle(s, c));
      chk_int($sformatf("rand_n_done_h3[%0d]", i), n3, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
